fingerprint_recorder: RTL and testbench
=======================================

FINGERPRINT_RECORDER -- requirements
Module: fingerprint_recorder

Interface
REQ-001 SHALL have parameter SAMPLE_DATA_WIDTH, default 8: width of the unsigned input sample and of the signed stored fingerprint word.
REQ-002 SHALL have parameter CAPTURE_LENGTH, default 1000: samples per averaging window and per recorded fingerprint.
REQ-003 SHALL have local SUM_WIDTH = $clog2(CAPTURE_LENGTH*(2**SAMPLE_DATA_WIDTH-1)+1) and ADDR_WIDTH = $clog2(CAPTURE_LENGTH).
REQ-004 SHALL use a single clock and a synchronous active-high reset, with ports as follows.
- clk  input  1: the single clock.
- rst  input  1: synchronous, active-high reset.
- record_start  input  1: one-cycle request to record a fingerprint.
- axiiv  input  1: sample valid.
- axiid  input  SAMPLE_DATA_WIDTH: unsigned sample.
- busy  output  1: high from an accepted start until done.
- done  output  1: one-cycle pulse when the recording is complete.
- mean_out  output  SAMPLE_DATA_WIDTH: computed window mean.
- wr_en  output  1: RAM write-port enable.
- wr_addr  output  ADDR_WIDTH: RAM write address.
- wr_data  output  SAMPLE_DATA_WIDTH: signed, mean-removed sample.

Function
REQ-005 SHALL implement states IDLE, SUM, DIVIDE, WRITE, DONE; all outputs registered.
REQ-006 IDLE: record_start=1 -> SUM; clear accumulator and sample counter; busy=1 next cycle. record_start is ignored in every other state.
REQ-007 SUM: each axiiv=1 cycle adds the zero-extended axiid to a SUM_WIDTH accumulator and increments the counter.
REQ-008 SUM: an axiiv=0 cycle clears the accumulator and counter. The window restarts; only CAPTURE_LENGTH contiguous valid samples count.
REQ-009 SUM: when the counter equals CAPTURE_LENGTH -> DIVIDE; the sample presented on that cycle is not accumulated.
REQ-010 DIVIDE: compute floor(accumulator / CAPTURE_LENGTH) with a sequential restoring divider, one quotient bit per cycle, SUM_WIDTH cycles. No combinational "/" operator.
REQ-011 On divider completion, mean_out SHALL take the low SAMPLE_DATA_WIDTH quotient bits and hold until the next accepted start or reset. State -> WRITE with the counter cleared.
REQ-012 Samples arriving in DIVIDE SHALL be discarded.
REQ-013 WRITE: each axiiv=1 cycle SHALL, one cycle later, set wr_en=1 and wr_addr=counter.
REQ-014 WRITE: on that same cycle, wr_data = saturate(axiid - mean_out). The difference is computed at SAMPLE_DATA_WIDTH+1 bits signed and clamped to [-2^(SAMPLE_DATA_WIDTH-1), 2^(SAMPLE_DATA_WIDTH-1)-1].
REQ-015 WRITE: axiiv=0 SHALL pause, giving wr_en=0 with the counter held; no restart.
REQ-016 WRITE: after the write to address CAPTURE_LENGTH-1 is issued -> DONE. Exactly CAPTURE_LENGTH writes occur per recording, addresses 0..CAPTURE_LENGTH-1 ascending, none repeated.
REQ-017 wr_en=0 in all states other than the cycle after an accepted WRITE sample. wr_addr and wr_data hold their last values when wr_en=0.
REQ-018 DONE: done=1 for exactly one cycle, busy=0 on that same cycle, then -> IDLE.
REQ-019 Illegal state encodings SHALL return to IDLE next cycle.

Reset
REQ-020 rst=1 SHALL, on the next edge, set state=IDLE, busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0, mean_out=0, and clear accumulator, counter and divider registers.
REQ-021 rst asserted mid-recording (any state) SHALL abort with no further writes. A partially written RAM is not repaired.
REQ-022 rst SHALL take priority over record_start on the same cycle.

Verification (CAPTURE_LENGTH=4, SAMPLE_DATA_WIDTH=8)
REQ-023 Constant input: start, then continuous axiid=100 -> mean_out=100; writes (0,0),(1,0),(2,0),(3,0); done single pulse.
REQ-024 Floor and saturation: SUM samples 10,20,30,41 (sum 101) -> mean_out=25. WRITE samples 200,0,25,152 -> wr_data 127 (saturated), -25 (0xE7), 0, 127.
REQ-025 Gap handling, covering both a SUM restart and a WRITE pause:
- SUM: samples 50,50, a gap, then 8,8,8,8 -> mean_out=8.
- WRITE: a 3-cycle gap -> no wr_en during the gap; addresses stay contiguous.
REQ-026 Reset mid-WRITE after 2 writes -> wr_en=0 and busy=0 next cycle. A subsequent start records normally from address 0.
REQ-027 record_start pulsed while busy -> ignored; exactly 4 writes and one done pulse result.
REQ-028 Latency check: the DIVIDE state lasts exactly SUM_WIDTH cycles (10 for these parameters), and the first wr_en occurs 1 cycle after the first valid WRITE-state sample.

Source files
------------

// File: rtl/fingerprint_recorder.sv
// Records a mean-removed fingerprint: averages CAPTURE_LENGTH contiguous samples, then writes
// the next CAPTURE_LENGTH samples minus that mean (saturated, signed) to an external RAM port.
module fingerprint_recorder #(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int CAPTURE_LENGTH    = 1000,
    localparam int SUM_WIDTH  = $clog2(CAPTURE_LENGTH * (2 ** SAMPLE_DATA_WIDTH - 1) + 1),
    localparam int ADDR_WIDTH = $clog2(CAPTURE_LENGTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         record_start,
    input  logic                         axiiv,
    input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
    output logic                         busy,
    output logic                         done,
    output logic [SAMPLE_DATA_WIDTH-1:0] mean_out,
    output logic                         wr_en,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic [SAMPLE_DATA_WIDTH-1:0] wr_data
);

    localparam int W         = SAMPLE_DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(CAPTURE_LENGTH + 1);
    localparam int DIV_WIDTH = $clog2(SUM_WIDTH + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SUM    = 3'd1;
    localparam logic [2:0] DIVIDE = 3'd2;
    localparam logic [2:0] WRITE  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(CAPTURE_LENGTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CAPTURE_LENGTH - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(SUM_WIDTH - 1);
    localparam logic [SUM_WIDTH:0]   DIVISOR  = (SUM_WIDTH + 1)'(CAPTURE_LENGTH);
    localparam logic [W-1:0]         SAT_MAX  = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0]         SAT_MIN  = {1'b1, {(W - 1){1'b0}}};

    logic [2:0]           state_q, state_d;
    logic [SUM_WIDTH-1:0] acc_q, acc_d;
    logic [SUM_WIDTH-1:0] rem_q, rem_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [W-1:0]         mean_q, mean_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0]         wr_data_q, wr_data_d;

    logic [SUM_WIDTH:0]   rem_shift;
    logic [SUM_WIDTH:0]   rem_sub;
    logic                 q_bit;
    logic [W:0]           diff;
    logic [W-1:0]         diff_sat;

    // acc_q doubles as the dividend/quotient shift register during DIVIDE.
    always_comb begin
        rem_shift = {rem_q, acc_q[SUM_WIDTH-1]};
        rem_sub   = rem_shift - DIVISOR;
        q_bit     = ~rem_sub[SUM_WIDTH];
    end

    always_comb begin
        diff = {1'b0, axiid} - {1'b0, mean_q};
        if (diff[W] != diff[W-1]) begin
            diff_sat = diff[W] ? SAT_MIN : SAT_MAX;
        end else begin
            diff_sat = diff[W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        div_cnt_d = div_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mean_d    = mean_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (record_start) begin
                    state_d = SUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    mean_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            SUM: begin
                if (cnt_q == CNT_FULL) begin
                    state_d   = DIVIDE;
                    rem_d     = '0;
                    div_cnt_d = '0;
                end else if (axiiv) begin
                    acc_d = acc_q + SUM_WIDTH'(axiid);
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            DIVIDE: begin
                acc_d     = {acc_q[SUM_WIDTH-2:0], q_bit};
                rem_d     = q_bit ? rem_sub[SUM_WIDTH-1:0] : rem_shift[SUM_WIDTH-1:0];
                div_cnt_d = div_cnt_q + 1'b1;
                if (div_cnt_q == DIV_LAST) begin
                    mean_d  = {acc_q[W-2:0], q_bit};
                    state_d = WRITE;
                    cnt_d   = '0;
                end
            end
            WRITE: begin
                if (axiiv) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
                    wr_data_d = diff_sat;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            div_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mean_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            div_cnt_q <= div_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mean_q    <= mean_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mean_out = mean_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_fingerprint_recorder.sv
// Bench for fingerprint_recorder (CAPTURE_LENGTH=4, SAMPLE_DATA_WIDTH=8): directed recordings with
// expected RAM writes queued up front and checked by an independent write monitor.
module tb_fingerprint_recorder;

    logic       clk = 1'b0;
    logic       rst;
    logic       record_start;
    logic       axiiv;
    logic [7:0] axiid;
    logic       busy;
    logic       done;
    logic [7:0] mean_out;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_e;

    fingerprint_recorder #(
        .SAMPLE_DATA_WIDTH(8),
        .CAPTURE_LENGTH   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .record_start(record_start),
        .axiiv       (axiiv),
        .axiid       (axiid),
        .busy        (busy),
        .done        (done),
        .mean_out    (mean_out),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d);
        axiiv = v;
        axiid = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'd0);
    endtask

    task automatic start_rec();
        record_start = 1'b1;
        cyc(1'b0, 8'd0);
        record_start = 1'b0;
    endtask

    task automatic push(input logic [1:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    // Write/done monitor
    initial begin
        forever begin
            @(negedge clk);
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %0d, expected no write",
                             wr_addr, wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", int'(wr_addr), int'(mon_e[9:8]));
                    chk("wr_data", int'(wr_data), int'(mon_e[7:0]));
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_low_at_done", int'(busy), 0);
                chk("done_single_cycle", int'(prev_done), 0);
            end
            prev_done = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int d0;
        int first;
        rst = 1'b1;
        record_start = 1'b1;
        axiiv = 1'b0;
        axiid = 8'd0;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_wr_addr", int'(wr_addr), 0);
        chk("reset_wr_data", int'(wr_data), 0);
        chk("reset_mean", int'(mean_out), 0);
        rst = 1'b0;
        record_start = 1'b0;
        idle(2);

        // Constant input, with latency measurement
        d0 = done_cnt;
        for (int a = 0; a < 4; a++) push(2'(a), 8'd0);
        start_rec();
        first = 0;
        for (int n = 1; n <= 25; n++) begin
            cyc(1'b1, 8'd100);
            if (n == 14) chk("mean_before_divide_end", int'(mean_out), 0);
            if (n == 15) chk("mean_at_divide_end", int'(mean_out), 100);
            if (wr_en && first == 0) first = n;
        end
        chk("first_wr_latency", first, 16);
        idle(3);
        chk("const_mean", int'(mean_out), 100);
        chk("const_done_pulses", done_cnt - d0, 1);
        chk("const_busy_after", int'(busy), 0);
        chk("const_queue_empty", exp_q.size(), 0);

        // Floor and saturation
        d0 = done_cnt;
        push(2'd0, 8'd127);
        push(2'd1, 8'hE7);
        push(2'd2, 8'd0);
        push(2'd3, 8'd127);
        start_rec();
        cyc(1'b1, 8'd10);
        cyc(1'b1, 8'd20);
        cyc(1'b1, 8'd30);
        cyc(1'b1, 8'd41);
        idle(11);
        cyc(1'b1, 8'd200);
        cyc(1'b1, 8'd0);
        cyc(1'b1, 8'd25);
        cyc(1'b1, 8'd152);
        idle(3);
        chk("floor_mean", int'(mean_out), 25);
        chk("floor_done_pulses", done_cnt - d0, 1);
        chk("floor_queue_empty", exp_q.size(), 0);

        // SUM restart and WRITE pause
        d0 = done_cnt;
        push(2'd0, 8'd0);
        push(2'd1, 8'd12);
        push(2'd2, 8'hF8);
        push(2'd3, 8'd127);
        start_rec();
        cyc(1'b1, 8'd50);
        cyc(1'b1, 8'd50);
        cyc(1'b0, 8'd0);
        repeat (4) cyc(1'b1, 8'd8);
        idle(11);
        cyc(1'b1, 8'd8);
        cyc(1'b1, 8'd20);
        for (int g = 0; g < 3; g++) begin
            cyc(1'b0, 8'd99);
            chk("gap_no_wr_en", int'(wr_en), 0);
        end
        cyc(1'b1, 8'd0);
        cyc(1'b1, 8'd255);
        idle(3);
        chk("gap_mean", int'(mean_out), 8);
        chk("gap_done_pulses", done_cnt - d0, 1);
        chk("gap_queue_empty", exp_q.size(), 0);

        // Reset mid-WRITE after two writes
        d0 = done_cnt;
        push(2'd0, 8'd3);
        push(2'd1, 8'd4);
        start_rec();
        cyc(1'b1, 8'd1);
        cyc(1'b1, 8'd2);
        cyc(1'b1, 8'd3);
        cyc(1'b1, 8'd4);
        idle(11);
        cyc(1'b1, 8'd5);
        cyc(1'b1, 8'd6);
        rst = 1'b1;
        cyc(1'b1, 8'd7);
        rst = 1'b0;
        chk("abort_wr_en", int'(wr_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_mean", int'(mean_out), 0);
        repeat (6) cyc(1'b1, 8'd9);
        idle(2);
        chk("abort_done_pulses", done_cnt - d0, 0);
        chk("abort_queue_empty", exp_q.size(), 0);

        // record_start pulses while busy are ignored
        d0 = done_cnt;
        push(2'd0, 8'd0);
        push(2'd1, 8'd10);
        push(2'd2, 8'hFC);
        push(2'd3, 8'hFF);
        start_rec();
        cyc(1'b1, 8'd4);
        record_start = 1'b1;
        cyc(1'b1, 8'd4);
        record_start = 1'b0;
        cyc(1'b1, 8'd4);
        cyc(1'b1, 8'd4);
        idle(4);
        record_start = 1'b1;
        cyc(1'b0, 8'd0);
        record_start = 1'b0;
        idle(6);
        cyc(1'b1, 8'd4);
        record_start = 1'b1;
        cyc(1'b1, 8'd14);
        record_start = 1'b0;
        cyc(1'b1, 8'd0);
        cyc(1'b1, 8'd3);
        idle(4);
        chk("busy_start_mean", int'(mean_out), 4);
        chk("busy_start_done_pulses", done_cnt - d0, 1);
        chk("busy_start_busy_after", int'(busy), 0);
        chk("busy_start_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
